// File: rtl/ebr_ram_reader.sv
// Burst reader for the block-RAM buffer: command -> bounded in-flight RAM reads -> valid/ready stream with o_last.
// First address one cycle after command accept, output one cycle after RAM data; EBR_RAM_READER_STRIDE_EN adds i_cmd_stride.
module ebr_ram_reader #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 1024,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [$clog2(DEPTH)-1:0] i_cmd_base,
  input  logic [$clog2(DEPTH):0]   i_cmd_len,
`ifdef EBR_RAM_READER_STRIDE_EN
  input  logic [$clog2(DEPTH)-1:0] i_cmd_stride,
`endif
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic                     o_ram_addr_valid,
  input  logic                     i_ram_addr_ready,
  input  logic [WIDTH-1:0]         i_ram_data,
  input  logic                     i_ram_valid,
  output logic                     o_ram_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_last,
  input  logic                     i_ready,
  output logic                     o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] issue_left;
  logic [LW-1:0] ret_cnt;
  logic [LW-1:0] ret_next;
  logic [OW-1:0] outstanding;
  logic [AW-1:0] step;
  logic [AW:0]   addr_sum;
  logic [AW-1:0] next_addr;
  logic          cmd_hs;
  logic          addr_hs;
  logic          data_hs;
  logic          out_hs;

  assign cmd_hs  = o_cmd_ready && i_cmd_valid;
  assign addr_hs = o_ram_addr_valid && i_ram_addr_ready;
  assign data_hs = i_ram_valid && o_ram_ready;
  assign out_hs  = o_valid && i_ready;

  // Valid only drops when the in-flight window is full, and that cannot happen while an address waits.
  assign o_ram_addr_valid = (state == ISSUE) && (outstanding < OW'(MAX_OUTSTANDING));
  assign o_ram_ready      = (outstanding != '0) && (!o_valid || i_ready);
  assign o_busy           = (state != IDLE) || o_valid;

  assign ret_next  = ret_cnt + LW'(1);
  assign addr_sum  = {1'b0, o_ram_addr} + {1'b0, step};
  assign next_addr = (addr_sum >= LW'(DEPTH)) ? AW'(addr_sum - LW'(DEPTH)) : addr_sum[AW-1:0];

`ifdef EBR_RAM_READER_STRIDE_EN
  logic [AW:0]   stride_ext;
  logic [AW-1:0] stride_mod;
  assign stride_ext = {1'b0, i_cmd_stride};
  assign stride_mod = (stride_ext >= LW'(DEPTH)) ? AW'(stride_ext - LW'(DEPTH)) : i_cmd_stride;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      step <= '0;
    else if (cmd_hs)
      step <= stride_mod;
  end
`else
  assign step = AW'(1);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      o_cmd_ready <= 1'b0;
      o_ram_addr  <= '0;
      len         <= '0;
      issue_left  <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_cmd_ready <= 1'b1;
          if (cmd_hs) begin
            o_ram_addr <= i_cmd_base;
            len        <= i_cmd_len;
            issue_left <= i_cmd_len;
            ret_cnt    <= '0;
            if (i_cmd_len != '0) begin
              state       <= ISSUE;
              o_cmd_ready <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (addr_hs) begin
            o_ram_addr <= next_addr;
            issue_left <= issue_left - LW'(1);
            if (issue_left == LW'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (data_hs && (ret_next == len)) begin
            state       <= IDLE;
            o_cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      case ({addr_hs, data_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (data_hs) begin
        ret_cnt <= ret_next;
        o_data  <= i_ram_data;
        o_valid <= 1'b1;
        o_last  <= (ret_next == len);
      end else if (out_hs) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ebr_ram_reader.sv
// Randomized bench for ebr_ram_reader: 2-cycle-latency RAM model, address/word scoreboards, directed corner cases.
module tb_ebr_ram_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int MAXO  = 3;
  localparam int AW    = 10;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic [AW-1:0]    i_cmd_base  = '0;
  logic [AW:0]      i_cmd_len   = '0;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic [AW-1:0]    o_ram_addr;
  logic             o_ram_addr_valid;
  logic             i_ram_addr_ready = 1'b0;
  logic [WIDTH-1:0] i_ram_data = '0;
  logic             i_ram_valid = 1'b0;
  logic             o_ram_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_last;
  logic             i_ready = 1'b0;
  logic             o_busy;
`ifdef EBR_RAM_READER_STRIDE_EN
  logic [AW-1:0]    i_cmd_stride = AW'(1);
`endif

  always #5 i_clock = ~i_clock;

  ebr_ram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cmd_base(i_cmd_base), .i_cmd_len(i_cmd_len),
`ifdef EBR_RAM_READER_STRIDE_EN
    .i_cmd_stride(i_cmd_stride),
`endif
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_ram_addr(o_ram_addr), .o_ram_addr_valid(o_ram_addr_valid), .i_ram_addr_ready(i_ram_addr_ready),
    .i_ram_data(i_ram_data), .i_ram_valid(i_ram_valid), .o_ram_ready(o_ram_ready),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready), .o_busy(o_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] mem_word(input int a);
    return a[WIDTH-1:0];
  endfunction

  // Reference: expected address sequence and {last,data} word sequence per accepted command.
  logic [AW-1:0] exp_addr[$];
  logic [8:0]    exp_word[$];
  int  outst = 0;
  int  addr_hs_cnt = 0;
  bit  ready_mode = 0, stall = 0, junk = 0;

  bit            rst_s = 1, addr_hs_s = 0, data_hs_s = 0;
  logic [AW-1:0] addr_s = '0;
  bit            prev_hold = 0, prev_ahold = 0;
  logic [8:0]    prev_word = '0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge i_clock) begin
    rst_s     = i_reset;
    addr_hs_s = o_ram_addr_valid && i_ram_addr_ready;
    addr_s    = o_ram_addr;
    data_hs_s = i_ram_valid && o_ram_ready;
    if (i_reset) begin
      exp_addr.delete();
      exp_word.delete();
      outst      = 0;
      prev_hold  = 0;
      prev_ahold = 0;
    end else begin
      if (prev_hold) chk("out_hold", {o_valid, o_last, o_data}, {1'b1, prev_word});
      if (prev_ahold) chk("addr_hold", {o_ram_addr_valid, o_ram_addr}, {1'b1, prev_addr});
      if (data_hs_s) chk("ack_needs_outstanding", outst > 0, 1);
      if (addr_hs_s) begin
        addr_hs_cnt++;
        if (exp_addr.size() == 0) chk("unexpected_addr", 1, 0);
        else chk("ram_addr", o_ram_addr, exp_addr.pop_front());
      end
      outst = outst + int'(addr_hs_s) - int'(data_hs_s);
      if (addr_hs_s) chk("outstanding_max", outst <= MAXO, 1);
      if (o_valid && i_ready) begin
        if (exp_word.size() == 0) chk("unexpected_word", {o_last, o_data}, 9'h1ff);
        else chk("word", {o_last, o_data}, exp_word.pop_front());
      end
      if (o_cmd_ready && i_cmd_valid) begin
        int step;
`ifdef EBR_RAM_READER_STRIDE_EN
        step = int'(i_cmd_stride) % DEPTH;
`else
        step = 1;
`endif
        addr_hs_cnt = 0;
        for (int i = 0; i < int'(i_cmd_len); i++) begin
          int a;
          a = (int'(i_cmd_base) + i * step) % DEPTH;
          exp_addr.push_back(AW'(a));
          exp_word.push_back({i == int'(i_cmd_len) - 1, mem_word(a)});
        end
      end
      prev_hold  = o_valid && !i_ready;
      prev_word  = {o_last, o_data};
      prev_ahold = o_ram_addr_valid && !i_ram_addr_ready;
      prev_addr  = o_ram_addr;
    end
  end

  // RAM model: word = address, 2-cycle address-to-data latency, returned words queue until acknowledged.
  logic [WIDTH-1:0] rq[$];
  bit               s0v = 0, s1v = 0;
  logic [WIDTH-1:0] s0d = '0, s1d = '0;

  always @(posedge i_clock) begin
    #1;
    if (rst_s) begin
      rq.delete();
      s0v = 0;
      s1v = 0;
    end else begin
      if (data_hs_s && rq.size() > 0) void'(rq.pop_front());
      if (s1v) rq.push_back(s1d);
      s1v = s0v;
      s1d = s0d;
      s0v = addr_hs_s;
      s0d = mem_word(int'(addr_s));
    end
    i_ram_valid      = (rq.size() > 0) || junk;
    i_ram_data       = (rq.size() > 0) ? rq[0] : 8'hEE;
    i_ram_addr_ready = ready_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_ready          = stall ? 1'b0 : (ready_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic send_cmd(input int base, input int len);
    bit ok = 0;
    @(posedge i_clock); #1;
    i_cmd_base  = AW'(base);
    i_cmd_len   = (AW+1)'(len);
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge i_clock);
      if (o_cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_timeout", 0, 1);
    @(posedge i_clock); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit check_busy);
    bit done = 0, seen_empty = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge i_clock); #2;
      if (exp_word.size() == 0 && exp_addr.size() == 0) begin
        if (check_busy && !seen_empty) chk("busy_after_last", o_busy, 0);
        seen_empty = 1;
        if (!o_busy) begin done = 1; break; end
      end
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_cmd_ready", o_cmd_ready, 0);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_addr_valid", o_ram_addr_valid, 0);
    chk("rst_ram_ready", o_ram_ready, 0);
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    repeat (2) @(negedge i_clock);
    chk("cmd_ready_after_reset", o_cmd_ready, 1);

    send_cmd(12'h010, 4);
    wait_done(1);
    send_cmd(12'h3FE, 4);
    wait_done(0);

    send_cmd(12'h000, 16);
    repeat (4) @(posedge i_clock);
    stall = 1;
    repeat (10) @(posedge i_clock);
    stall = 0;
    wait_done(0);

    send_cmd(12'h055, 0);
    repeat (5) begin
      @(negedge i_clock);
      chk("len0_addr_valid", o_ram_addr_valid, 0);
      chk("len0_valid", o_valid, 0);
      chk("len0_cmd_ready", o_cmd_ready, 1);
    end

    send_cmd(12'h100, 8);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge i_clock); #2;
      if (addr_hs_cnt >= 2) begin ok = 1; break; end
    end
    chk("two_addr_timeout", ok, 1);
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("mid_rst_outputs", {o_cmd_ready, o_ram_addr_valid, o_ram_ready, o_valid, o_last, o_busy}, 0);
    chk("mid_rst_addr_data", {o_ram_addr, o_data}, 0);
    junk = 1;
    repeat (4) @(posedge i_clock);
    junk = 0;
    repeat (2) @(posedge i_clock);
    send_cmd(12'h020, 2);
    wait_done(0);

`ifdef EBR_RAM_READER_STRIDE_EN
    i_cmd_stride = AW'(4);
    send_cmd(12'h000, 3);
    wait_done(0);
`endif

    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
`ifdef EBR_RAM_READER_STRIDE_EN
      i_cmd_stride = AW'($urandom_range(0, DEPTH - 1));
`endif
      send_cmd($urandom_range(0, DEPTH - 1),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 12));
      if ($urandom_range(0, 1) == 0) wait_done(0);
    end
    wait_done(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
